// File: rtl/serial_tx_fifo.sv
// Buffered 8N1 serial transmitter: small character FIFO feeding an LSB-first
// shifter. Every bit (start, data, stop) lasts exactly TERM_COUNT clocks.
module serial_tx_fifo #(
  parameter int unsigned CLOCK_FREQUENCY = 100000000,
  parameter int unsigned BAUD_RATE       = 9600,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic       clk100,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  output logic       tx_full,
  output logic       tx_busy,
  output logic       tx_overflow,
  output logic       tx
);

  localparam int unsigned TERM_COUNT = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int unsigned TMR_W      = (TERM_COUNT > 2) ? $clog2(TERM_COUNT) : 1;
  localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W      = PTR_W + 1;

  localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(TERM_COUNT - 1);
  localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic [1:0]       state_q,   state_d;
  logic [TMR_W-1:0] tmr_q,     tmr_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q,   shift_d;
  logic [PTR_W-1:0] wr_ptr_q,  wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q,  rd_ptr_d;
  logic [CNT_W-1:0] count_q,   count_d;
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [7:0]       mem_d [FIFO_DEPTH];
  logic             tx_q,      tx_d;
  logic             full_q,    full_d;
  logic             busy_q,    busy_d;
  logic             ovf_q,     ovf_d;

  logic fifo_full;
  logic fifo_nonempty;
  logic push;
  logic pop;
  logic tmr_done;

  assign fifo_full     = (count_q == CNT_FULL);
  assign fifo_nonempty = (count_q != '0);
  assign push          = tx_load & ~fifo_full;
  assign tmr_done      = (tmr_q == '0);

  // FIFO write side, pointer/count bookkeeping and sticky overflow
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push) begin
      mem_d[wr_ptr_q] = tx_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (tx_load && fifo_full) begin
      ovf_d = 1'b1;
    end
  end

  // Frame sequencer: start bit, eight data bits LSB-first, stop bit
  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    pop       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (fifo_nonempty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          tmr_d   = TMR_RELOAD;
          state_d = ST_START;
          tx_d    = 1'b0;
        end
      end
      ST_START: begin
        tx_d = 1'b0;
        if (tmr_done) begin
          tmr_d     = TMR_RELOAD;
          bit_cnt_d = 3'd0;
          state_d   = ST_DATA;
          tx_d      = shift_q[0];
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_DATA: begin
        if (tmr_done) begin
          tmr_d = TMR_RELOAD;
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + 3'd1;
            tx_d      = shift_q[1];
          end
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_STOP: begin
        tx_d = 1'b1;
        if (tmr_done) begin
          if (fifo_nonempty) begin
            // next character starts with no idle gap
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            tmr_d   = TMR_RELOAD;
            state_d = ST_START;
            tx_d    = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        tmr_d   = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

  // Registered status flags computed from post-edge state and count
  always_comb begin
    full_d = (count_d == CNT_FULL);
    busy_d = (state_d != ST_IDLE) || (count_d != '0);
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk100 or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      tmr_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      tx_q      <= 1'b1;
      full_q    <= 1'b0;
      busy_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      mem_q     <= mem_d;
      tx_q      <= tx_d;
      full_q    <= full_d;
      busy_q    <= busy_d;
      ovf_q     <= ovf_d;
    end
  end

  assign tx          = tx_q;
  assign tx_full     = full_q;
  assign tx_busy     = busy_q;
  assign tx_overflow = ovf_q;

endmodule
